csa_multi_adder: RTL and testbench
==================================

Name: csa_multi_adder

Overview:
- N-operand unsigned adder built from a 3:2 carry-save compressor tree, then a carry-lookahead final adder.
- Optional register after every compressor level.
- Valid/ready handshake with global-stall backpressure.
- Per-beat accumulate mode that adds the tree result into a running sum.
- Used in the frequency-stabilisation datapath to sum error/phase terms and integrate them over time.

Parameters:
- Width, 32, operand width in bits (4..64).
- Nops, 4, number of operands (2..16).
- Pipe, 1: 1 = register after every compressor level; 0 = tree purely combinational.
- AccW, 40, accumulator/output width. Must be ≥ Width+clog2(Nops); elaboration error otherwise.

Ports:
- i_clkp  in  1  clock, rising edge
- i_rstn  in  1  synchronous active-low reset, sampled on i_clkp rising edge
- i_ops  in  Nops*Width  packed operands; operand k is bits [k*Width +: Width]
- i_valid  in  1  input beat valid
- o_ready  out  1  block can accept a beat this cycle
- i_acc  in  1  beat result is added to the accumulator (0 = result replaces it)
- i_clr  in  1  clear accumulator to 0 when this beat reaches the output stage
- o_d  out  AccW  sum / accumulator value
- o_c  out  1  accumulator wrapped (carry out of AccW) on this beat
- o_valid  out  1  output beat valid
- i_ready  in  1  downstream accepts the output

Behaviour:
- **Reset** (i_rstn=0 at clock edge): all pipeline valid bits = 0, accumulator = 0, o_d = 0, o_c = 0, o_valid = 0. o_ready = 1 from the first cycle after reset.
- **Reset mid-operation:** in-flight beats are discarded; no output is produced for them.
- **Tree levels (LEV):** Nops=2 → 0, 3 → 1, 4 → 2, 5–6 → 3, 7–9 → 4, 10–13 → 5, 14–16 → 6.
- **Latency:** L = Pipe*LEV + 1 cycles from input accept (i_valid & o_ready) to o_valid, absent stall.
- **Throughput:** 1 beat/cycle.
- **Stall rule:** adv = ~o_valid | i_ready.
  - o_ready = adv, combinational.
  - All pipeline registers, including i_acc/i_clr sidebands and valid bits, load only when adv=1; otherwise they hold.
  - o_d and o_valid are stable while o_valid=1 and i_ready=0.
  - No beat is dropped or duplicated.
- **Arithmetic:** tree result T = sum of operands, zero-extended to AccW; exact, never truncated.
- **Output stage** (on a valid beat, adv=1):
  - base = 0 if i_clr=1, or if i_acc=0. Otherwise base = accumulator.
  - R = base + T.
  - accumulator <= R mod 2^AccW; o_d <= same value; o_c <= carry out of bit AccW-1.
  - Non-accumulate beats: o_c = 0.
  - i_clr=1 with i_acc=1: clear applies first, so o_d = T.
- **Bubbles:** an invalid beat at the output stage leaves the accumulator and o_c unchanged. o_valid follows the valid bit.
- **Simultaneous events:**
  - Input accept and output consume in the same cycle are legal (full rate).
  - Reset has priority over everything.
- **Final adder:** Width-generic carry-lookahead, carry-in 0, combinational. Placed between the last tree register and the output register.

Optional Feature:
- Macro: CSA_MULTI_ADDER_SAT_EN.
- **Defined:** on carry out of AccW, accumulator and o_d saturate to all-ones (2^AccW - 1) instead of wrapping, and o_c = 1. A saturated accumulator stays saturated on further positive adds until i_clr or i_acc=0.
- **Undefined:** modulo wrap as described in Behaviour; no saturation logic is synthesised.

Test Plan:
- Width=8, Nops=4, Pipe=1, AccW=10, i_acc=0: ops {255,255,255,255} → o_d=1020, o_c=0, o_valid exactly 3 cycles after accept.
- Same config, back-to-back beats {1,2,3,4}, {10,20,30,40}, i_ready=1 → o_d=10 then 100 on consecutive cycles; o_ready held 1.
- Accumulate: beats of {100,100,100,100} (T=400) with i_acc=1; first beat i_clr=1 → o_d=400, 800, then 176 with o_c=1 (1200 mod 1024). With CSA_MULTI_ADDER_SAT_EN: 400, 800, 1023 with o_c=1.
- Backpressure: i_ready=0 for 5 cycles while 4 beats are offered → o_ready drops once the pipe is full, o_d holds; after release, all 4 results emerge in order with none lost.
- Reset mid-flight: 2 beats in the tree, assert i_rstn=0 for 1 cycle → o_valid=0, o_d=0, accumulator=0; a next beat {5,5,5,5} with i_acc=1 gives o_d=20.
- Nops=2, Pipe=0: latency 1; ops {0xFF,0x01} with Width=8, AccW=9 → o_d=256.

Source files
------------

// File: rtl/csa_multi_adder.sv
// csa_multi_adder: N-operand unsigned adder.
// Wallace-style 3:2 carry-save tree, optionally registered after every
// compressor level, followed by a Kogge-Stone carry-lookahead final adder
// and an output/accumulator register with valid/ready flow control.
// Optional feature macro: CSA_MULTI_ADDER_SAT_EN (saturating accumulator).
module csa_multi_adder #(
  parameter int Width = 32,
  parameter int Nops  = 4,
  parameter int Pipe  = 1,
  parameter int AccW  = 40
) (
  input  logic                    i_clkp,
  input  logic                    i_rstn,
  input  logic [Nops*Width-1:0]   i_ops,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_acc,
  input  logic                    i_clr,
  output logic [AccW-1:0]         o_d,
  output logic                    o_c,
  output logic                    o_valid,
  input  logic                    i_ready
);

  // Number of partial-sum rows entering compressor level lvl.
  function automatic int cnt_at(input int lvl);
    int n;
    n = Nops;
    for (int i = 0; i < lvl; i++) n = n - n / 3;
    return n;
  endfunction

  // Compressor levels needed to reduce Nops rows down to two.
  function automatic int lev_calc();
    int n;
    int l;
    n = Nops;
    l = 0;
    while (n > 2) begin
      n = n - n / 3;
      l++;
    end
    return l;
  endfunction

  // Majority (carry) output of a 3:2 compressor, already weighted by 2.
  // The bit shifted out is always zero because every partial sum is
  // bounded by the exact total, which fits in AccW bits.
  function automatic logic [AccW-1:0] csa_carry(input logic [AccW-1:0] a,
                                                input logic [AccW-1:0] b,
                                                input logic [AccW-1:0] c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

`ifdef CSA_MULTI_ADDER_SAT_EN
  // Clamp an AccW+1 bit result to the largest AccW-bit value on overflow.
  function automatic logic [AccW-1:0] sat_fold(input logic [AccW:0] r);
    return r[AccW] ? {AccW{1'b1}} : r[AccW-1:0];
  endfunction
`endif

  localparam int LEV = lev_calc();

  // Elaboration-time parameter sanity checks.
  if (AccW < Width + $clog2(Nops)) begin : g_chk_accw
    $error("csa_multi_adder: AccW too small for Width and Nops");
  end
  if (Width < 4 || Width > 64) begin : g_chk_width
    $error("csa_multi_adder: Width out of range 4..64");
  end
  if (Nops < 2 || Nops > 16) begin : g_chk_nops
    $error("csa_multi_adder: Nops out of range 2..16");
  end

  logic adv;
  logic vld_t;
  logic acc_t;
  logic clr_t;

  // Global stall: everything advances unless a held output is not taken.
  assign adv     = ~o_valid | i_ready;
  assign o_ready = adv;

  // ---- compressor tree: level l consumes cin, produces cout for l+1 ----
  for (genvar l = 0; l <= LEV; l++) begin : g_lvl
    localparam int CI = cnt_at(l);
    logic [AccW-1:0] cin [0:CI-1];

    if (l == 0) begin : g_src
      // Zero-extend each operand to the accumulator width.
      always_comb begin
        for (int k = 0; k < CI; k++) begin
          cin[k] = {{(AccW-Width){1'b0}}, i_ops[k*Width +: Width]};
        end
      end
    end else if (Pipe != 0) begin : g_reg
      // Level boundary register; data carries no reset, only valid does.
      always_ff @(posedge i_clkp) begin
        if (adv) cin <= g_lvl[l-1].g_cmp.cout;
      end
    end else begin : g_wire
      // Purely combinational tree: pass rows straight through.
      always_comb begin
        cin = g_lvl[l-1].g_cmp.cout;
      end
    end

    if (l < LEV) begin : g_cmp
      localparam int G  = CI / 3;
      localparam int CO = CI - G;
      logic [AccW-1:0] cout [0:CO-1];

      // Groups of three rows compress to sum+carry; leftovers pass through.
      always_comb begin
        for (int g = 0; g < G; g++) begin
          cout[2*g]   = cin[3*g] ^ cin[3*g+1] ^ cin[3*g+2];
          cout[2*g+1] = csa_carry(cin[3*g], cin[3*g+1], cin[3*g+2]);
        end
        for (int k = 3 * G; k < CI; k++) begin
          cout[k-G] = cin[k];
        end
      end
    end
  end

  // ---- sideband (valid / accumulate / clear) travelling with the data ----
  if (Pipe != 0 && LEV > 0) begin : g_sb
    logic [LEV-1:0] vld_q;
    logic [LEV-1:0] acc_q;
    logic [LEV-1:0] clr_q;

    // Valid bits are control state: reset clears them, discarding in-flight beats.
    always_ff @(posedge i_clkp) begin
      if (!i_rstn) begin
        vld_q <= '0;
      end else if (adv) begin
        vld_q[0] <= i_valid;
        for (int l = 1; l < LEV; l++) vld_q[l] <= vld_q[l-1];
      end
    end

    // Accumulate/clear flags are only meaningful alongside a valid bit.
    always_ff @(posedge i_clkp) begin
      if (adv) begin
        acc_q[0] <= i_acc;
        clr_q[0] <= i_clr;
        for (int l = 1; l < LEV; l++) begin
          acc_q[l] <= acc_q[l-1];
          clr_q[l] <= clr_q[l-1];
        end
      end
    end

    assign vld_t = vld_q[LEV-1];
    assign acc_t = acc_q[LEV-1];
    assign clr_t = clr_q[LEV-1];
  end else begin : g_sb_wire
    assign vld_t = i_valid;
    assign acc_t = i_acc;
    assign clr_t = i_clr;
  end

  // ---- final carry-lookahead adder (two remaining rows, carry-in 0) ----
  logic [AccW-1:0] fa_a;
  logic [AccW-1:0] fa_b;
  logic [AccW-1:0] tree_sum;
  logic [AccW-2:0] gk;
  logic [AccW-2:0] pk;

  assign fa_a = g_lvl[LEV].cin[0];
  assign fa_b = g_lvl[LEV].cin[1];

  // Kogge-Stone prefix over generate/propagate; the top carry is never needed.
  always_comb begin
    gk = fa_a[AccW-2:0] & fa_b[AccW-2:0];
    pk = fa_a[AccW-2:0] ^ fa_b[AccW-2:0];
    for (int d = 1; d < AccW - 1; d = d * 2) begin
      for (int i = AccW - 2; i >= d; i--) begin
        gk[i] = gk[i] | (pk[i] & gk[i-d]);
        pk[i] = pk[i] & pk[i-d];
      end
    end
    tree_sum = (fa_a ^ fa_b) ^ {gk, 1'b0};
  end

  // ---- output stage: accumulator, carry flag, output valid ----
  logic [AccW-1:0] sum_q;
  logic [AccW-1:0] sum_d;
  logic            c_q;
  logic            c_d;
  logic            ovld_q;
  logic [AccW-1:0] base;
  logic [AccW:0]   sum_ext;

  // Clear wins over accumulate; bubbles leave accumulator and carry untouched.
  always_comb begin
    base    = (acc_t && !clr_t) ? sum_q : '0;
    sum_ext = {1'b0, base} + {1'b0, tree_sum};
    sum_d   = sum_q;
    c_d     = c_q;
    if (vld_t) begin
`ifdef CSA_MULTI_ADDER_SAT_EN
      sum_d = sat_fold(sum_ext);
`else
      sum_d = sum_ext[AccW-1:0];
`endif
      c_d   = sum_ext[AccW];
    end
  end

  // Output register doubles as the running accumulator; held under stall.
  always_ff @(posedge i_clkp) begin
    if (!i_rstn) begin
      sum_q  <= '0;
      c_q    <= 1'b0;
      ovld_q <= 1'b0;
    end else if (adv) begin
      sum_q  <= sum_d;
      c_q    <= c_d;
      ovld_q <= vld_t;
    end
  end

  assign o_d     = sum_q;
  assign o_c     = c_q;
  assign o_valid = ovld_q;

endmodule

// File: tb/tb_csa_multi_adder.sv
// Directed bench for csa_multi_adder: a Width=8/Nops=4/Pipe=1/AccW=10
// instance (latency 3) and a Width=8/Nops=2/Pipe=0/AccW=9 instance (latency 1).
module tb_csa_multi_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;

  logic [31:0] ops0;
  logic        vld0, acc0, clr0, rdy0;
  logic        ordy0;
  logic [9:0]  d0;
  logic        c0, ov0;

  logic [15:0] ops1;
  logic        vld1, acc1, clr1, rdy1;
  logic        ordy1;
  logic [8:0]  d1;
  logic        c1, ov1;

  int n_cmp = 0;
  int n_err = 0;

`ifdef CSA_MULTI_ADDER_SAT_EN
  localparam int ACC3_D = 1023;
  localparam int U1_D2  = 511;
`else
  localparam int ACC3_D = 176;
  localparam int U1_D2  = 254;
`endif

  csa_multi_adder #(.Width(8), .Nops(4), .Pipe(1), .AccW(10)) u0 (
    .i_clkp(clk), .i_rstn(rstn), .i_ops(ops0), .i_valid(vld0), .o_ready(ordy0),
    .i_acc(acc0), .i_clr(clr0), .o_d(d0), .o_c(c0), .o_valid(ov0), .i_ready(rdy0)
  );

  csa_multi_adder #(.Width(8), .Nops(2), .Pipe(0), .AccW(9)) u1 (
    .i_clkp(clk), .i_rstn(rstn), .i_ops(ops1), .i_valid(vld1), .o_ready(ordy1),
    .i_acc(acc1), .i_clr(clr1), .o_d(d1), .o_c(c1), .o_valid(ov1), .i_ready(rdy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set4(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic [7:0] d);
    ops0 = {d, c, b, a};
  endtask

  initial begin
    rstn = 1'b0;
    ops0 = '0; vld0 = 1'b0; acc0 = 1'b0; clr0 = 1'b0; rdy0 = 1'b1;
    ops1 = '0; vld1 = 1'b0; acc1 = 1'b0; clr1 = 1'b0; rdy1 = 1'b1;
    step();
    step();
    rstn = 1'b1;

    // Reset state
    chk("rst_ovalid", ov0, 0);
    chk("rst_od", d0, 0);
    chk("rst_oc", c0, 0);
    chk("rst_oready", ordy0, 1);
    chk("rst_u1_ovalid", ov1, 0);
    chk("rst_u1_oready", ordy1, 1);

    // Max operands, latency exactly 3
    set4(255, 255, 255, 255); vld0 = 1'b1; acc0 = 1'b0; clr0 = 1'b0;
    step();
    vld0 = 1'b0;
    chk("lat_c1_ovalid", ov0, 0);
    step();
    chk("lat_c2_ovalid", ov0, 0);
    step();
    chk("lat_c3_ovalid", ov0, 1);
    chk("max_od", d0, 1020);
    chk("max_oc", c0, 0);
    step();
    chk("max_after_ovalid", ov0, 0);

    // Back-to-back beats at full rate
    set4(1, 2, 3, 4); vld0 = 1'b1;
    chk("b2b_oready_a", ordy0, 1);
    step();
    set4(10, 20, 30, 40);
    chk("b2b_oready_b", ordy0, 1);
    step();
    vld0 = 1'b0;
    step();
    chk("b2b_ovalid_a", ov0, 1);
    chk("b2b_od_a", d0, 10);
    step();
    chk("b2b_ovalid_b", ov0, 1);
    chk("b2b_od_b", d0, 100);
    step();
    chk("b2b_drain_ovalid", ov0, 0);

    // Accumulate with clear on the first beat, third beat overflows
    set4(100, 100, 100, 100); vld0 = 1'b1; acc0 = 1'b1; clr0 = 1'b1;
    step();
    clr0 = 1'b0;
    step();
    step();
    vld0 = 1'b0;
    chk("acc1_od", d0, 400);
    chk("acc1_oc", c0, 0);
    step();
    chk("acc2_od", d0, 800);
    chk("acc2_oc", c0, 0);
    step();
    chk("acc3_ovalid", ov0, 1);
    chk("acc3_od", d0, ACC3_D);
    chk("acc3_oc", c0, 1);
    step();
    chk("acc_bubble_ovalid", ov0, 0);
    chk("acc_bubble_od", d0, ACC3_D);
    chk("acc_bubble_oc", c0, 1);
    acc0 = 1'b0;
    step();

    // Backpressure: downstream stalls for 5 edges while 4 beats are offered
    rdy0 = 1'b0;
    set4(1, 1, 1, 1); vld0 = 1'b1;
    step();
    set4(2, 2, 2, 2);
    step();
    set4(3, 3, 3, 3);
    step();
    set4(4, 4, 4, 4);
    chk("bp_full_oready", ordy0, 0);
    chk("bp_full_ovalid", ov0, 1);
    chk("bp_full_od", d0, 4);
    chk("bp_full_oc", c0, 0);
    step();
    chk("bp_hold1_od", d0, 4);
    chk("bp_hold1_oready", ordy0, 0);
    step();
    chk("bp_hold2_od", d0, 4);
    chk("bp_hold2_ovalid", ov0, 1);
    rdy0 = 1'b1;
    #1;
    chk("bp_release_oready", ordy0, 1);
    step();
    vld0 = 1'b0;
    chk("bp_out2_od", d0, 8);
    chk("bp_out2_ovalid", ov0, 1);
    step();
    chk("bp_out3_od", d0, 12);
    step();
    chk("bp_out4_od", d0, 16);
    chk("bp_out4_ovalid", ov0, 1);
    step();
    chk("bp_drain_ovalid", ov0, 0);

    // Reset with two beats in flight
    set4(7, 7, 7, 7); vld0 = 1'b1; acc0 = 1'b1;
    step();
    step();
    vld0 = 1'b0;
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    chk("midrst_ovalid", ov0, 0);
    chk("midrst_od", d0, 0);
    chk("midrst_oc", c0, 0);
    set4(5, 5, 5, 5); vld0 = 1'b1; acc0 = 1'b1; clr0 = 1'b0;
    step();
    vld0 = 1'b0;
    chk("midrst_noghost1", ov0, 0);
    step();
    chk("midrst_noghost2", ov0, 0);
    step();
    chk("midrst_new_ovalid", ov0, 1);
    chk("midrst_new_od", d0, 20);
    acc0 = 1'b0;
    step();

    // Two-operand combinational tree, latency 1
    ops1 = {8'h01, 8'hFF}; vld1 = 1'b1; acc1 = 1'b0;
    step();
    chk("u1_ovalid", ov1, 1);
    chk("u1_od", d1, 256);
    chk("u1_oc", c1, 0);
    ops1 = {8'hFF, 8'hFF}; acc1 = 1'b1;
    step();
    vld1 = 1'b0;
    chk("u1_acc_od", d1, U1_D2);
    chk("u1_acc_oc", c1, 1);
    step();
    chk("u1_bubble_ovalid", ov1, 0);
    chk("u1_bubble_od", d1, U1_D2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
